spi32_slave: RTL and testbench

SPI mode 0 responder that is the far end of the `spi32` initiator link. It oversamples `sclk`/`cs`/`sdi` on the system clock. Received bytes are shifted into a 32-bit word, and a preloaded 32-bit response word is shifted out on `sdo`. The block sits in the peripheral-side design (or loopback bench) and exposes the same 32-bit word-level interface style as `spi32`, with a load/ready handshake for transmit data and a one-cycle valid pulse for receive data.

---
 rtl/spi32_slave.sv | 175 +++++++++++++++++
 tb/tb_spi32_slave.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi32_slave.sv
`default_nettype none
// spi32_slave - oversampled SPI mode-0 responder with 32-bit word interface. Rev 1.0
// Define SPI32_SLAVE_TX_EN to build the transmit path; otherwise receive-only.
module spi32_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_FILL     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din,
  input  logic        load,
  output logic        tx_ready,
  output logic [31:0] dout,
  output logic [2:0]  rx_count,
  output logic        rx_valid,
  output logic        rx_overflow,
  output logic        busy,
  input  logic        sclk,
  input  logic        sdi,
  output logic        sdo,
  input  logic        cs
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync, sdi_sync;
  logic cs_d, sclk_d;
  logic cs_s, sclk_s, sdi_s;
  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  logic [2:0]  bit_cnt;
  logic [2:0]  byte_cnt;
  logic [7:0]  byte_sr;
  logic [31:0] rx_word;
  logic        ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      sdi_sync  <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

`ifdef SPI32_SLAVE_TX_EN
  logic [31:0] tx_shift;
  logic [31:0] tx_shadow;
  logic [2:0]  fill_idx;

  // Each falling edge follows bit_cnt rising edges, so this walks TX_FILL MSB first
  // and the fill bits reach sdo as whole TX_FILL bytes once the word is exhausted.
  assign fill_idx = 3'd0 - bit_cnt;
`else
  logic unused_tx;
  assign unused_tx = ^{din, load, TX_FILL};
  assign sdo       = 1'b0;
  assign tx_ready  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rx_valid    <= 1'b0;
      dout        <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      byte_sr     <= '0;
      rx_word     <= '0;
      ovf         <= 1'b0;
`ifdef SPI32_SLAVE_TX_EN
      tx_shift    <= '0;
      tx_shadow   <= '0;
      tx_ready    <= 1'b1;
      sdo         <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI32_SLAVE_TX_EN
      if (load && tx_ready) begin
        tx_shadow <= din;
        tx_ready  <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= ACTIVE;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            byte_sr  <= '0;
            rx_word  <= '0;
            ovf      <= 1'b0;
`ifdef SPI32_SLAVE_TX_EN
            // A load in this same cycle only sees tx_ready=1, so it lands for the next frame.
            if (!tx_ready) begin
              tx_shift <= tx_shadow;
              sdo      <= tx_shadow[31];
              tx_ready <= 1'b1;
            end else begin
              tx_shift <= {4{TX_FILL}};
              sdo      <= TX_FILL[7];
            end
`endif
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state <= DONE;
`ifdef SPI32_SLAVE_TX_EN
            sdo   <= 1'b0;
`endif
          end else begin
            if (sclk_rise) begin
              byte_sr <= {byte_sr[6:0], sdi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_word <= {rx_word[23:0], byte_sr[6:0], sdi_s};
                if (byte_cnt == 3'd4) ovf <= 1'b1;
                else                  byte_cnt <= byte_cnt + 3'd1;
              end
            end
`ifdef SPI32_SLAVE_TX_EN
            if (sclk_fall) begin
              tx_shift <= {tx_shift[30:0], TX_FILL[fill_idx]};
              sdo      <= tx_shift[30];
            end
`endif
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (byte_cnt != 3'd0) begin
            dout        <= rx_word;
            rx_count    <= byte_cnt;
            rx_overflow <= ovf;
            rx_valid    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi32_slave.sv
`default_nettype none
// tb_spi32_slave - directed self-checking bench for spi32_slave (mode-0 master model).
module tb_spi32_slave;

  localparam int HALF = 8;
`ifdef SPI32_SLAVE_TX_EN
  localparam bit TX_ON = 1'b1;
`else
  localparam bit TX_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] din = '0;
  logic        load = 1'b0;
  logic        tx_ready;
  logic [31:0] dout;
  logic [2:0]  rx_count;
  logic        rx_valid;
  logic        rx_overflow;
  logic        busy;
  logic        sclk = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        cs = 1'b1;

  int checks = 0;
  int passes = 0;
  int valid_total = 0;

  always #5 clk = ~clk;

  spi32_slave #(.SYNC_STAGES(2), .TX_FILL(8'hFF)) dut (
    .clk(clk), .reset(reset), .din(din), .load(load), .tx_ready(tx_ready),
    .dout(dout), .rx_count(rx_count), .rx_valid(rx_valid), .rx_overflow(rx_overflow),
    .busy(busy), .sclk(sclk), .sdi(sdi), .sdo(sdo), .cs(cs)
  );

  always @(negedge clk) if (rx_valid === 1'b1) valid_total++;

  task automatic do_load(input logic [31:0] w);
    @(negedge clk);
    din  = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic spi_bits(input int nbits, input logic [63:0] mosi, output logic [63:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      sdi = mosi[63-i];
      repeat (HALF) @(negedge clk);
      miso = {miso[62:0], sdo};
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_frame(input int nbits, input logic [63:0] mosi, output logic [63:0] miso);
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(nbits, mosi, miso);
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (dout !== 32'h0) $display("FAIL reset dout: got %h want %h", dout, 32'h0); else passes++;
    checks++; if (rx_count !== 3'd0) $display("FAIL reset rx_count: got %0d want 0", rx_count); else passes++;
    checks++; if (rx_valid !== 1'b0) $display("FAIL reset rx_valid: got %b want 0", rx_valid); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL reset rx_overflow: got %b want 0", rx_overflow); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else passes++;
    checks++; if (sdo !== 1'b0) $display("FAIL reset sdo: got %b want 0", sdo); else passes++;
    checks++; if (tx_ready !== TX_ON) $display("FAIL reset tx_ready: got %b want %b", tx_ready, TX_ON); else passes++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_frame_timing;
    int v0;
    v0 = valid_total;
    @(negedge clk);
    cs = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (busy !== 1'b0) $display("FAIL timing busy_early: got %b want 0", busy); else passes++;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) $display("FAIL timing busy_start: got %b want 1", busy); else passes++;
    checks++; if (sdo !== TX_ON) $display("FAIL timing first_sdo: got %b want %b", sdo, TX_ON); else passes++;
    @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL timing busy_end: got %b want 0", busy); else passes++;
    checks++; if (valid_total !== v0) $display("FAIL timing no_valid: got %0d pulses want 0", valid_total - v0); else passes++;
  endtask

  task automatic test_four_byte;
    logic [63:0] m;
    int v0;
    do_load(32'hA5C3_0F81);
    #1;
    checks++; if (tx_ready !== 1'b0) $display("FAIL four_byte tx_ready_after_load: got %b want 0", tx_ready); else passes++;
    v0 = valid_total;
    spi_frame(32, {32'h1234_5678, 32'h0}, m);
    checks++; if (m[31:0] !== (TX_ON ? 32'hA5C3_0F81 : 32'h0)) $display("FAIL four_byte miso: got %h want %h", m[31:0], TX_ON ? 32'hA5C3_0F81 : 32'h0); else passes++;
    checks++; if (dout !== 32'h1234_5678) $display("FAIL four_byte dout: got %h want %h", dout, 32'h1234_5678); else passes++;
    checks++; if (rx_count !== 3'd4) $display("FAIL four_byte rx_count: got %0d want 4", rx_count); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL four_byte overflow: got %b want 0", rx_overflow); else passes++;
    checks++; if (valid_total - v0 !== 1) $display("FAIL four_byte valid_pulses: got %0d want 1", valid_total - v0); else passes++;
    checks++; if (tx_ready !== TX_ON) $display("FAIL four_byte tx_ready_after: got %b want %b", tx_ready, TX_ON); else passes++;
  endtask

  task automatic test_one_byte;
    logic [63:0] m;
    int v0;
    v0 = valid_total;
    spi_frame(8, {8'h3C, 56'h0}, m);
    checks++; if (m[7:0] !== (TX_ON ? 8'hFF : 8'h00)) $display("FAIL one_byte miso: got %h want %h", m[7:0], TX_ON ? 8'hFF : 8'h00); else passes++;
    checks++; if (dout !== 32'h0000_003C) $display("FAIL one_byte dout: got %h want %h", dout, 32'h0000_003C); else passes++;
    checks++; if (rx_count !== 3'd1) $display("FAIL one_byte rx_count: got %0d want 1", rx_count); else passes++;
    checks++; if (valid_total - v0 !== 1) $display("FAIL one_byte valid_pulses: got %0d want 1", valid_total - v0); else passes++;
  endtask

  task automatic test_overflow;
    logic [63:0] m;
    int v0;
    v0 = valid_total;
    spi_frame(48, {48'h0102_0304_0506, 16'h0}, m);
    checks++; if (m[47:0] !== (TX_ON ? 48'hFFFF_FFFF_FFFF : 48'h0)) $display("FAIL overflow miso: got %h want %h", m[47:0], TX_ON ? 48'hFFFF_FFFF_FFFF : 48'h0); else passes++;
    checks++; if (dout !== 32'h0304_0506) $display("FAIL overflow dout: got %h want %h", dout, 32'h0304_0506); else passes++;
    checks++; if (rx_count !== 3'd4) $display("FAIL overflow rx_count: got %0d want 4", rx_count); else passes++;
    checks++; if (rx_overflow !== 1'b1) $display("FAIL overflow flag: got %b want 1", rx_overflow); else passes++;
    checks++; if (valid_total - v0 !== 1) $display("FAIL overflow valid_pulses: got %0d want 1", valid_total - v0); else passes++;
  endtask

  task automatic test_abort;
    logic [63:0] m;
    int v0;
    v0 = valid_total;
    spi_frame(5, {5'b10110, 59'h0}, m);
    checks++; if (valid_total !== v0) $display("FAIL abort valid_pulses: got %0d want 0", valid_total - v0); else passes++;
    checks++; if (dout !== 32'h0304_0506) $display("FAIL abort dout_held: got %h want %h", dout, 32'h0304_0506); else passes++;
    checks++; if (rx_count !== 3'd4) $display("FAIL abort rx_count_held: got %0d want 4", rx_count); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL abort busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_load_ignored;
    logic [63:0] m;
    do_load(32'hDEAD_BEEF);
    #1;
    checks++; if (tx_ready !== 1'b0) $display("FAIL load_ignored tx_ready: got %b want 0", tx_ready); else passes++;
    do_load(32'h1111_1111);
    spi_frame(32, {32'hCAFE_F00D, 32'h0}, m);
    checks++; if (m[31:0] !== (TX_ON ? 32'hDEAD_BEEF : 32'h0)) $display("FAIL load_ignored miso: got %h want %h", m[31:0], TX_ON ? 32'hDEAD_BEEF : 32'h0); else passes++;
    checks++; if (dout !== 32'hCAFE_F00D) $display("FAIL load_ignored dout: got %h want %h", dout, 32'hCAFE_F00D); else passes++;
    checks++; if (rx_overflow !== 1'b0) $display("FAIL load_ignored overflow: got %b want 0", rx_overflow); else passes++;
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] m;
    int v0;
    do_load(32'h0F0F_0F0F);
    @(negedge clk);
    cs = 1'b0;
    repeat (HALF) @(negedge clk);
    spi_bits(3, {3'b101, 61'h0}, m);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("FAIL mid_reset busy: got %b want 0", busy); else passes++;
    checks++; if (dout !== 32'h0) $display("FAIL mid_reset dout: got %h want 0", dout); else passes++;
    checks++; if (rx_count !== 3'd0) $display("FAIL mid_reset rx_count: got %0d want 0", rx_count); else passes++;
    checks++; if (sdo !== 1'b0) $display("FAIL mid_reset sdo: got %b want 0", sdo); else passes++;
    checks++; if (tx_ready !== TX_ON) $display("FAIL mid_reset tx_ready: got %b want %b", tx_ready, TX_ON); else passes++;
    sclk = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    v0 = valid_total;
    spi_bits(8, {8'hAA, 56'h0}, m);
    checks++; if (busy !== 1'b0) $display("FAIL mid_reset not_joined: got busy %b want 0", busy); else passes++;
    repeat (HALF) @(negedge clk);
    cs = 1'b1;
    repeat (12) @(negedge clk);
    checks++; if (valid_total !== v0) $display("FAIL mid_reset no_valid: got %0d pulses want 0", valid_total - v0); else passes++;
    spi_frame(8, {8'h55, 56'h0}, m);
    checks++; if (dout !== 32'h0000_0055) $display("FAIL mid_reset next_dout: got %h want %h", dout, 32'h0000_0055); else passes++;
    checks++; if (rx_count !== 3'd1) $display("FAIL mid_reset next_rx_count: got %0d want 1", rx_count); else passes++;
    checks++; if (valid_total - v0 !== 1) $display("FAIL mid_reset next_valid: got %0d want 1", valid_total - v0); else passes++;
    checks++; if (m[7:0] !== (TX_ON ? 8'hFF : 8'h00)) $display("FAIL mid_reset next_miso: got %h want %h", m[7:0], TX_ON ? 8'hFF : 8'h00); else passes++;
  endtask

  initial begin
    test_reset;
    test_frame_timing;
    test_four_byte;
    test_one_byte;
    test_overflow;
    test_abort;
    test_load_ignored;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
